// File: rtl/cache_req_responder_pkg.sv
// Shared widths, FSM states and address helpers for the
// cache request responder.
package cache_pkg;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int INDEX_W = 2;
    localparam int TAG_W   = ADDR_W - INDEX_W;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        BUS_WAIT,
        MEM,
        DONE
    } state_t;

    function automatic logic [INDEX_W-1:0] get_index(
        input logic [ADDR_W-1:0] addr
    );
        return INDEX_W'(addr);
    endfunction

    function automatic logic [TAG_W-1:0] get_tag(
        input logic [ADDR_W-1:0] addr
    );
        return TAG_W'(addr >> INDEX_W);
    endfunction

endpackage

// File: rtl/cache_req_responder_if.sv
// Memory bus between the cache responder (master) and the
// shared memory (slave).
interface cache_req_responder_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);

    logic              bus_busy;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack, bus_busy
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack, bus_busy
    );

endinterface

// File: rtl/cache_req_responder_line_array.sv
// Direct-mapped line storage: combinational lookup,
// one synchronous write port, cleared on reset.
module cache_line_array #(
    parameter int INDEX_W = 2,
    parameter int TAG_W   = 6,
    parameter int DATA_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] index,
    output logic               valid,
    output logic [TAG_W-1:0]   tag,
    output logic [DATA_W-1:0]  data,
    input  logic               we,
    input  logic [TAG_W-1:0]   wtag,
    input  logic [DATA_W-1:0]  wdata
);

    localparam int LINES = 1 << INDEX_W;

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES];

    assign valid = valid_q[index];
    assign tag   = tag_q[index];
    assign data  = data_q[index];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < LINES; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else if (we) begin
            valid_q[index] <= 1'b1;
            tag_q[index]   <= wtag;
            data_q[index]  <= wdata;
        end
    end

endmodule

// File: rtl/cache_req_responder.sv
// Write-through, no-write-allocate direct-mapped cache
// responder between the CPU request port and the memory bus.
module cache_req_responder
    import cache_pkg::*;
#(
    parameter int ADDR_W  = cache_pkg::ADDR_W,
    parameter int DATA_W  = cache_pkg::DATA_W,
    parameter int INDEX_W = cache_pkg::INDEX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_to_cache,
    input  logic              read_operation,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data,
    output logic              cache_busy,
    output logic              done,
    output logic              hit,
    output logic [DATA_W-1:0] read_data,
    cache_req_responder_if.master mem,
    output logic [7:0]        hit_count,
    output logic [7:0]        miss_count
);

    localparam int LINE_TAG_W = ADDR_W - INDEX_W;

    state_t state, state_next;

    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_data;
    logic                  req_read;
    logic [INDEX_W-1:0]    req_index;
    logic [LINE_TAG_W-1:0] req_tag;

    logic                  line_valid;
    logic [LINE_TAG_W-1:0] line_tag;
    logic [DATA_W-1:0]     line_data;
    logic                  line_we;
    logic [DATA_W-1:0]     line_wdata;
    logic                  lookup_hit;

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    assign req_index  = get_index(req_addr);
    assign req_tag    = get_tag(req_addr);
    assign lookup_hit = line_valid && (line_tag == req_tag);

    cache_line_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (LINE_TAG_W),
        .DATA_W  (DATA_W)
    ) u_lines (
        .clk   (clk),
        .rst   (rst),
        .index (req_index),
        .valid (line_valid),
        .tag   (line_tag),
        .data  (line_data),
        .we    (line_we),
        .wtag  (req_tag),
        .wdata (line_wdata)
    );

    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_next;
    end

    always_comb begin
        state_next = state;
        line_we    = 1'b0;
        line_wdata = req_data;
        unique case (state)
            IDLE: begin
                if (start_to_cache && !cache_busy)
                    state_next = LOOKUP;
            end
            LOOKUP: begin
                if (req_read && lookup_hit) begin
                    state_next = DONE;
                end else begin
                    state_next = BUS_WAIT;
                    line_we    = !req_read && lookup_hit;
                end
            end
            BUS_WAIT: begin
                if (!mem.bus_busy)
                    state_next = MEM;
            end
            MEM: begin
                if (mem.mem_ack) begin
                    state_next = DONE;
                    line_we    = req_read;
                    line_wdata = mem.mem_rdata;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // cache_busy stays high through the done cycle, so a start
    // seen while done is high is dropped as well
    always_ff @(posedge clk) begin
        if (rst) begin
            cache_busy    <= 1'b0;
            done          <= 1'b0;
            hit           <= 1'b0;
            read_data     <= '0;
            hit_count     <= '0;
            miss_count    <= '0;
            req_addr      <= '0;
            req_data      <= '0;
            req_read      <= 1'b0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cache_busy) begin
                        cache_busy <= 1'b0;
                    end else if (start_to_cache) begin
                        req_addr   <= address;
                        req_data   <= data;
                        req_read   <= read_operation;
                        cache_busy <= 1'b1;
                    end
                end
                LOOKUP: begin
                    hit <= lookup_hit;
                    if (lookup_hit) begin
                        hit_count <= sat_inc(hit_count);
                        if (req_read)
                            read_data <= line_data;
                    end else begin
                        miss_count <= sat_inc(miss_count);
                    end
                end
                BUS_WAIT: begin
                    if (!mem.bus_busy) begin
                        mem.mem_req   <= 1'b1;
                        mem.mem_we    <= !req_read;
                        mem.mem_addr  <= req_addr;
                        mem.mem_wdata <= req_read ? '0 : req_data;
                    end
                end
                MEM: begin
                    if (mem.mem_ack) begin
                        mem.mem_req   <= 1'b0;
                        mem.mem_we    <= 1'b0;
                        mem.mem_addr  <= '0;
                        mem.mem_wdata <= '0;
                        if (req_read) begin
                            read_data <= mem.mem_rdata;
                            hit       <= 1'b0;
                        end
                    end
                end
                DONE:    done <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_req_responder.sv
// Randomized self-checking bench for cache_req_responder with a
// line/memory reference model and a bench-side memory responder.
module tb_cache_req_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_to_cache;
    logic       read_operation;
    logic [7:0] address;
    logic [7:0] data;
    logic       cache_busy;
    logic       done;
    logic       hit;
    logic [7:0] read_data;
    logic [7:0] hit_count;
    logic [7:0] miss_count;

    always #5 clk = ~clk;

    cache_req_responder_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    cache_req_responder dut (
        .clk            (clk),
        .rst            (rst),
        .start_to_cache (start_to_cache),
        .read_operation (read_operation),
        .address        (address),
        .data           (data),
        .cache_busy     (cache_busy),
        .done           (done),
        .hit            (hit),
        .read_data      (read_data),
        .mem            (bus.master),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic       ref_v   [4];
    logic [5:0] ref_t   [4];
    logic [7:0] ref_d   [4];
    logic [7:0] ref_mem [256];
    logic [7:0] bus_mem [256];
    int         ref_hits;
    int         ref_misses;
    logic [7:0] ref_rd;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) ref_v[i] = 1'b0;
        ref_hits   = 0;
        ref_misses = 0;
        ref_rd     = 8'h00;
    endtask

    task automatic do_req(input bit rd, input logic [7:0] a,
                          input logic [7:0] wd, input int busy_n,
                          input int ack_dly, input bit glitch);
        int idx, req_n, ack_n, done_n, exp_req, req_exp_n;
        bit exp_hit;
        idx     = int'(a[1:0]);
        exp_hit = ref_v[idx] && (ref_t[idx] == a[7:2]);
        if (exp_hit) ref_hits = (ref_hits == 255) ? 255 : ref_hits + 1;
        else ref_misses = (ref_misses == 255) ? 255 : ref_misses + 1;
        if (rd) begin
            if (!exp_hit) begin
                ref_v[idx] = 1'b1;
                ref_t[idx] = a[7:2];
                ref_d[idx] = ref_mem[a];
            end
            ref_rd = ref_d[idx];
        end else begin
            if (exp_hit) ref_d[idx] = wd;
            ref_mem[a] = wd;
        end
        exp_req = (rd && exp_hit) ? 0 : 1;

        @(negedge clk);
        start_to_cache = 1'b1;
        read_operation = rd;
        address        = a;
        data           = wd;
        @(posedge clk);
        #1;
        start_to_cache = 1'b0;
        req_n  = 0;
        ack_n  = 0;
        done_n = 0;
        for (int n = 1; n <= 60 && done_n == 0; n++) begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (glitch) begin
                start_to_cache = (n == 1);
                address        = 8'h55;
                data           = 8'hEE;
            end
            if (n == 1) chk("busy_set", 32'(cache_busy), 1);
            else if (req_n == 0) chk("busy_hold", 32'(cache_busy), 1);
            if (ack_n != 0 && n == ack_n + 1)
                chk("req_drop", 32'(bus.mem_req), 0);
            if (req_n == 0 && bus.mem_req) begin
                req_n = n;
                chk("mem_we", 32'(bus.mem_we), 32'(!rd));
                chk("mem_addr", 32'(bus.mem_addr), 32'(a));
                chk("mem_wdata", 32'(bus.mem_wdata),
                    rd ? 0 : 32'(wd));
            end else if (req_n != 0 && ack_n == 0) begin
                chk("req_hold", 32'(bus.mem_req), 1);
                chk("addr_hold", 32'(bus.mem_addr), 32'(a));
            end
            if (done) done_n = n;
            if (req_n == 0) bus.bus_busy = (n <= busy_n);
            else bus.bus_busy = 1'($urandom_range(1));
            if (req_n != 0 && ack_n == 0 && n >= req_n + ack_dly) begin
                ack_n       = n;
                bus.mem_ack = 1'b1;
                if (bus.mem_we) bus_mem[bus.mem_addr] = bus.mem_wdata;
                else bus.mem_rdata = bus_mem[bus.mem_addr];
            end
        end
        start_to_cache = glitch;
        bus.bus_busy   = 1'b0;
        chk("done_seen", 32'(done_n != 0), 1);
        chk("mem_used", 32'(req_n != 0), exp_req);
        if (exp_req != 0) begin
            req_exp_n = ((busy_n + 1 > 2) ? busy_n + 1 : 2) + 1;
            chk("req_time", req_n, req_exp_n);
            chk("done_time", done_n, ack_n + 2);
        end else begin
            chk("hit_time", done_n, 3);
        end
        chk("hit", 32'(hit), 32'(exp_hit));
        chk("read_data", 32'(read_data), 32'(ref_rd));
        chk("hit_count", 32'(hit_count), ref_hits);
        chk("miss_count", 32'(miss_count), ref_misses);
        @(negedge clk);
        start_to_cache = 1'b0;
        chk("busy_clr", 32'(cache_busy), 0);
        chk("done_pulse", 32'(done), 0);
        if (glitch) begin
            @(negedge clk);
            chk("glitch_idle", 32'(cache_busy), 0);
            chk("glitch_req", 32'(bus.mem_req), 0);
        end
    endtask

    initial begin
        rst            = 1'b1;
        start_to_cache = 1'b0;
        read_operation = 1'b0;
        address        = 8'h00;
        data           = 8'h00;
        bus.bus_busy   = 1'b0;
        bus.mem_ack    = 1'b0;
        bus.mem_rdata  = 8'h00;
        for (int i = 0; i < 256; i++) begin
            bus_mem[i] = 8'($urandom);
            ref_mem[i] = bus_mem[i];
        end
        bus_mem[8'h14] = 8'hA5;
        ref_mem[8'h14] = 8'hA5;
        model_reset();

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(cache_busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_hit", 32'(hit), 0);
        chk("rst_rdata", 32'(read_data), 0);
        chk("rst_req", 32'(bus.mem_req), 0);
        chk("rst_we", 32'(bus.mem_we), 0);
        chk("rst_addr", 32'(bus.mem_addr), 0);
        chk("rst_wdata", 32'(bus.mem_wdata), 0);
        chk("rst_hits", 32'(hit_count), 0);
        chk("rst_misses", 32'(miss_count), 0);
        rst = 1'b0;

        do_req(1'b1, 8'h14, 8'h00, 0, 0, 1'b0);
        do_req(1'b1, 8'h14, 8'h00, 0, 0, 1'b0);
        do_req(1'b0, 8'h14, 8'h3C, 0, 1, 1'b0);
        do_req(1'b1, 8'h14, 8'h00, 0, 0, 1'b0);
        do_req(1'b0, 8'h20, 8'h77, 0, 2, 1'b0);
        do_req(1'b1, 8'h20, 8'h00, 0, 0, 1'b0);
        do_req(1'b1, 8'h14, 8'h00, 0, 0, 1'b0);
        do_req(1'b1, 8'h24, 8'h00, 0, 0, 1'b0);
        do_req(1'b1, 8'h14, 8'h00, 0, 0, 1'b0);
        do_req(1'b1, 8'h33, 8'h00, 6, 1, 1'b0);
        do_req(1'b0, 8'h15, 8'h9A, 2, 0, 1'b1);
        do_req(1'b1, 8'h15, 8'h00, 0, 0, 1'b1);

        repeat (60) begin
            do_req(1'($urandom_range(1)), 8'($urandom_range(0, 15)),
                   8'($urandom), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 7) == 0);
        end

        repeat (260) do_req(1'b1, 8'h14, 8'h00, 0, 0, 1'b0);
        repeat (130) begin
            do_req(1'b1, 8'h18, 8'h00, 0, 0, 1'b0);
            do_req(1'b1, 8'h28, 8'h00, 0, 0, 1'b0);
        end

        do_req(1'b1, 8'h14, 8'h00, 0, 0, 1'b0);
        @(negedge clk);
        start_to_cache = 1'b1;
        read_operation = 1'b1;
        address        = 8'h24;
        @(posedge clk);
        #1;
        start_to_cache = 1'b0;
        for (int k = 0; k < 10 && !bus.mem_req; k++) @(negedge clk);
        chk("rst_mid_req", 32'(bus.mem_req), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_drop", 32'(bus.mem_req), 0);
        chk("rst_mid_done", 32'(done), 0);
        chk("rst_mid_busy", 32'(cache_busy), 0);
        chk("rst_mid_hits", 32'(hit_count), 0);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rst_mid_nodone", 32'(done), 0);
        do_req(1'b1, 8'h14, 8'h00, 0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_req_responder.md
Name: cache_req_responder

Overview:
- Cache-side responder for the CPU-to-cache request interface: accepts a single read or write request, looks it up in a direct-mapped cache, and answers the CPU.
- On a miss or a write, it forwards the access to the memory bus once the bus is free.
- Write-through, no-write-allocate; read misses fill the line.
- Sits between the CPU request port and the shared memory bus.

Parameters:
ADDR_W, 8, address width
DATA_W, 8, data width
INDEX_W, 2, line index bits (2**INDEX_W lines); tag = ADDR_W-INDEX_W bits

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
start_to_cache  in  1  request strobe from CPU
read_operation  in  1  1=read, 0=write; sampled with start_to_cache
address  in  ADDR_W  request address
data  in  DATA_W  write data
cache_busy  out  1  high while a request is in progress
done  out  1  one-cycle completion pulse
hit  out  1  valid with done; 1 = request hit
read_data  out  DATA_W  read result; valid with done, held until next done
bus_busy  in  1  memory bus occupied by another master
mem_req  out  1  memory request; held until mem_ack
mem_we  out  1  1 = memory write
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data; valid with mem_ack
mem_ack  in  1  one-cycle memory completion
hit_count  out  8  saturating hit counter
miss_count  out  8  saturating miss counter

Behaviour:
- Reset values:
  - All outputs 0.
  - All valid bits cleared.
  - State IDLE.
  - Counters 0.
  - Reset mid-operation aborts the request immediately: mem_req drops on the next edge, and no done is issued.
- Acceptance:
  - In IDLE, start_to_cache=1 latches address, data and read_operation.
  - cache_busy goes 1 from the next cycle until the cycle after done.
  - start_to_cache while cache_busy=1 is ignored and nothing is queued.
- FSM states: IDLE, LOOKUP, BUS_WAIT, MEM, DONE.
- LOOKUP, read hit:
  - read_data <= line data; hit <= 1; hit_count++ (saturates at 255).
  - Next state DONE.
- LOOKUP, read miss:
  - miss_count++ (saturates at 255).
  - Next state BUS_WAIT.
- LOOKUP, write hit:
  - Line data <= latched data; hit <= 1; hit_count++.
  - Next state BUS_WAIT.
- LOOKUP, write miss:
  - Line unchanged; hit <= 0; miss_count++.
  - Next state BUS_WAIT.
- BUS_WAIT:
  - Wait while bus_busy=1.
  - When bus_busy=0: assert mem_req with mem_addr=latched address, mem_we=!read_operation, mem_wdata=latched data (0 for reads).
  - Next state MEM.
- MEM:
  - Hold mem_req and its fields stable until mem_ack; bus_busy is ignored once mem_req is asserted.
  - On mem_ack for a read: line[index] <= {valid=1, tag, mem_rdata}; read_data <= mem_rdata; hit <= 0.
  - On mem_ack for a write: no line change.
  - mem_req drops on the edge after mem_ack. Next state DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency (request accepted at edge E0):
  - Read hit: done high in the cycle after edge E0+2.
  - Miss or write: done is asserted 1 cycle after the mem_ack edge.
  - With bus_busy=0 and zero-wait memory (mem_ack in the cycle after mem_req rises), a miss completes at E0+4.
- mem_ack outside MEM is ignored.
- Conflict read miss (same index, different tag) overwrites the line.
- Line storage: combinational read, synchronous write; one write port per cycle; clear-all on reset.

Decomposition:
- Shared package cache_pkg:
  - State enum.
  - Default widths ADDR_W, DATA_W, INDEX_W.
  - Functions get_index and get_tag.
- One sub-module, cache_line_array:
  - valid, tag and data arrays.
  - Combinational lookup by index.
  - Synchronous single-port write.
  - Synchronous clear on rst.

Test Plan:
- Reset, then read 0x14 -> miss; mem_req with mem_we=0, mem_addr=0x14; memory returns 0xA5 -> done, hit=0, read_data=0xA5, miss_count=1. Repeat read 0x14 -> done 2 cycles after accept, hit=1, read_data=0xA5, no mem_req, hit_count=1.
- After the fill, write 0x14 data 0x3C -> hit=1, mem_req with mem_we=1, mem_wdata=0x3C. Then read 0x14 -> hit, read_data=0x3C.
- Write 0x20 data 0x77 (never filled) -> memory write issued, hit=0. Next read 0x20 -> miss (no allocate).
- Read 0x14 (fill), then read 0x24 (same index 0) -> miss that replaces the line; read 0x14 again -> miss.
- Hold bus_busy=1 for 5 cycles during a miss -> mem_req stays 0 and cache_busy stays 1. bus_busy falls -> mem_req next cycle. Raise bus_busy after mem_req -> mem_req held until ack.
- Pulse start_to_cache while busy with address 0x55 -> ignored, no extra done. Assert rst during MEM -> mem_req=0 next cycle, no done, and a later read 0x14 misses.
